// File: rtl/c_group_capture.sv
`default_nettype none
// ============================================================================
//  Module   : c_group_capture
//  Purpose  : Registered capture of the 36 driven bits of the C vector into a
//             small circular FIFO. Each entry carries a per-nibble parity
//             vector and a sequence number and is presented on valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module c_group_capture #(
    parameter int IN_W   = 41,
    parameter int GROUPS = 9,
    parameter int DEPTH  = 2,
    parameter int SEQ_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [IN_W-1:0]            in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4*GROUPS-1:0]        out_data,
    output logic [GROUPS-1:0]          out_parity,
    output logic [SEQ_W-1:0]           out_seq,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_DW = 4 * GROUPS;
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    // Pointers, occupancy and counters
    logic [c_AW-1:0]  r_wp, r_rp;
    logic [c_AW-1:0]  w_wp_nxt, w_rp_nxt;
    logic [c_CW-1:0]  r_count, w_count_nxt;
    logic [SEQ_W-1:0] r_seq, w_seq_nxt;
    logic [CNT_W-1:0] r_stall, w_stall_nxt;

    // Entry storage
    logic [c_DW-1:0]   r_mem_data [DEPTH];
    logic [GROUPS-1:0] r_mem_par  [DEPTH];
    logic [SEQ_W-1:0]  r_mem_seq  [DEPTH];

    logic              w_push, w_pop;
    logic [GROUPS-1:0] w_par;

    // One parity bit per captured nibble; upper undriven bits never enter.
    for (genvar g = 0; g < GROUPS; g++) begin : g_parity
        assign w_par[g] = ^in_data[4*g +: 4];
    end

    // Bits above the driven range are deliberately dropped.
    if (IN_W > c_DW) begin : g_upper_drop
        logic w_unused_upper;
        assign w_unused_upper = ^in_data[IN_W-1:c_DW];
    end

    // Handshake flags depend only on the occupancy register.
    assign in_ready   = (r_count != c_FULL);
    assign out_valid  = (r_count != '0);
    assign out_data   = r_mem_data[r_rp];
    assign out_parity = r_mem_par[r_rp];
    assign out_seq    = r_mem_seq[r_rp];
    assign stall_cnt  = r_stall;
    assign count      = r_count;

    // Next-state for pointers, occupancy, sequence and stall counter.
    always_comb begin
        w_push      = in_valid && in_ready;
        w_pop       = out_valid && out_ready;
        w_wp_nxt    = r_wp;
        w_rp_nxt    = r_rp;
        w_count_nxt = r_count;
        w_seq_nxt   = r_seq;
        w_stall_nxt = r_stall;
        if (w_push) begin
            w_wp_nxt  = r_wp + 1'b1;
            w_seq_nxt = r_seq + 1'b1;
        end
        if (w_pop) begin
            w_rp_nxt = r_rp + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
        if (in_valid && !in_ready && (r_stall != {CNT_W{1'b1}})) begin
            w_stall_nxt = r_stall + 1'b1;
        end
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_seq   <= '0;
            r_stall <= '0;
        end else begin
            r_wp    <= w_wp_nxt;
            r_rp    <= w_rp_nxt;
            r_count <= w_count_nxt;
            r_seq   <= w_seq_nxt;
            r_stall <= w_stall_nxt;
        end
    end

    // Entry storage: cleared on reset so an empty FIFO reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_par[i]  <= '0;
                r_mem_seq[i]  <= '0;
            end
        end else if (w_push) begin
            r_mem_data[r_wp] <= in_data[c_DW-1:0];
            r_mem_par[r_wp]  <= w_par;
            r_mem_seq[r_wp]  <= r_seq;
        end
    end

endmodule
`default_nettype wire
